// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              spr_req;
   logic              spr_we;
   logic [ADDR_W-1:0] spr_addr;
   logic [DATA_W-1:0] spr_wdata;
   logic              spr_gnt;
   logic              spr_rvalid;
   logic [DATA_W-1:0] spr_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  spr_req, spr_we, spr_addr, spr_wdata,
      output spr_gnt, spr_rvalid, spr_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output spr_req, spr_we, spr_addr, spr_wdata,
      input  spr_gnt, spr_rvalid, spr_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (cpu=0, spr=1) arbiter for a single-port synchronous memory, one access in flight.
// Define MEM_ARB_RR_EN for round-robin; default is cpu priority with a sprite starvation escape.
module mem_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RDONE} state_t;

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [1:0]             req;
   logic [1:0]             we;
   logic [1:0][ADDR_W-1:0] addr;
   logic [1:0][DATA_W-1:0] wdata;

   assign req   = {bus.spr_req,   bus.cpu_req};
   assign we    = {bus.spr_we,    bus.cpu_we};
   assign addr  = {bus.spr_addr,  bus.cpu_addr};
   assign wdata = {bus.spr_wdata, bus.cpu_wdata};

   state_t                 state;
   logic                   owner;
   logic [CNT_W-1:0]       lat_cnt;
   logic [1:0]             gnt;
   logic [1:0]             rvalid;
   logic [1:0][DATA_W-1:0] rdata;
   logic                   mem_en;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic                   busy;
   logic                   win;

`ifdef MEM_ARB_RR_EN
   logic last_win;

   // On conflict the port that lost last time goes; a lone requester always wins.
   always_comb begin
      win = ~req[0];
      if (req == 2'b11) win = ~last_win;
   end
`else
   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic [SC_W-1:0] starve_cnt;

   always_comb begin
      win = req[1] & (~req[0] | (starve_cnt == SC_W'(STARVE_MAX)));
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         lat_cnt   <= '0;
         gnt       <= '0;
         rvalid    <= '0;
         rdata     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_win  <= 1'b0;
`else
         starve_cnt <= '0;
`endif
      end else begin
         gnt    <= '0;
         rvalid <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  mem_en     <= 1'b1;
                  mem_we     <= we[win];
                  mem_addr   <= addr[win];
                  mem_wdata  <= wdata[win];
                  owner      <= win;
                  gnt[win]   <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ACCESS;
`ifdef MEM_ARB_RR_EN
                  last_win   <= win;
`endif
               end else begin
                  mem_en <= 1'b0;
               end
`ifndef MEM_ARB_RR_EN
               // Only cpu wins over a waiting spr advance the count.
               if (!req[1] || win)
                  starve_cnt <= '0;
               else if (starve_cnt != SC_W'(STARVE_MAX))
                  starve_cnt <= starve_cnt + 1'b1;
`endif
            end
            ACCESS: begin
               mem_en <= 1'b0;
               if (mem_we) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  lat_cnt <= CNT_W'(RD_LAT - 1);
                  state   <= RWAIT;
               end
            end
            RWAIT: begin
               if (lat_cnt == '0) begin
                  rdata[owner]  <= bus.mem_rdata;
                  rvalid[owner] <= 1'b1;
                  state         <= RDONE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RDONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_gnt    = gnt[0];
   assign bus.spr_gnt    = gnt[1];
   assign bus.cpu_rvalid = rvalid[0];
   assign bus.spr_rvalid = rvalid[1];
   assign bus.cpu_rdata  = rdata[0];
   assign bus.spr_rdata  = rdata[1];
   assign bus.mem_en     = mem_en;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.busy       = busy;
endmodule
